// File: rtl/wide_add_sequencer_pkg.sv
// Shared types and constants for the slice-serial wide adder.
// Holds the FSM state enum, slice width and slice-count helpers.
package wide_add_sequencer_pkg;

  localparam int SLICE_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int ns_of(input int width);
    return width / SLICE_W;
  endfunction

  function automatic int idx_w(input int ns);
    return (ns > 1) ? $clog2(ns) : 1;
  endfunction

endpackage

// File: rtl/wide_add_sequencer_brentkung.sv
// 16-bit Brent-Kung prefix adder with carry-in.
// Ports: a_i, b_i, ci_i in; sum_o, co_o out.
module brentkung (
  input  logic [15:0] a_i,
  input  logic [15:0] b_i,
  input  logic        ci_i,
  output logic [15:0] sum_o,
  output logic        co_o
);

  logic [15:0] p;
  logic [15:0] c;

  assign p = a_i ^ b_i;

  // gg[i] ends as the carry out of bit i.
  // Carry-in is folded into bit 0's generate.
  always_comb begin
    logic [15:0] gg;
    logic [15:0] pp;
    gg    = a_i & b_i;
    pp    = p;
    gg[0] = gg[0] | (pp[0] & ci_i);
    for (int d = 0; d < 4; d++) begin
      for (int i = 0; i < 16; i++) begin
        if ((i % (2 << d)) == ((2 << d) - 1)) begin
          gg[i] = gg[i] | (pp[i] & gg[i - (1 << d)]);
          pp[i] = pp[i] & pp[i - (1 << d)];
        end
      end
    end
    for (int d = 2; d >= 0; d--) begin
      for (int i = 0; i < 16; i++) begin
        if ((i >= (2 << d)) &&
            ((i % (2 << d)) == ((1 << d) - 1))) begin
          gg[i] = gg[i] | (pp[i] & gg[i - (1 << d)]);
        end
      end
    end
    c = gg;
  end

  assign sum_o = p ^ {c[14:0], ci_i};
  assign co_o  = c[15];

endmodule

// File: rtl/wide_add_sequencer.sv
// WIDTH-bit add/sub done as WIDTH/16 serial slices on one adder.
// Ports: clk, rst, in_valid/in_ready, a, b, sub, cin,
//        out_valid/out_ready, sum, cout, ovf.
module wide_add_sequencer
  import wide_add_sequencer_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NS = ns_of(WIDTH);
  localparam int IW = idx_w(NS);
  localparam logic [IW-1:0] LAST = IW'(NS - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q, sum_q;
  logic             carry_q, cout_q, ovf_q;
  logic [IW-1:0]    idx_q;

  logic [SLICE_W-1:0] a_sl, b_sl, s_sl;
  logic               co;
  logic               is_last;

  assign is_last = (idx_q == LAST);

  always_comb begin
    a_sl = '0;
    b_sl = '0;
    for (int i = 0; i < NS; i++) begin
      if (idx_q == IW'(i)) begin
        a_sl = a_q[i*SLICE_W +: SLICE_W];
        b_sl = b_q[i*SLICE_W +: SLICE_W];
      end
    end
  end

  brentkung u_bk (
    .a_i   (a_sl),
    .b_i   (b_sl),
    .ci_i  (carry_q),
    .sum_o (s_sl),
    .co_o  (co)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (in_valid)  state_d = RUN;
      RUN:     if (is_last)   state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
  end

  // Subtraction is a + ~b + 1; b is stored pre-inverted.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (state_q == IDLE && in_valid) begin
      a_q     <= a;
      b_q     <= sub ? ~b : b;
      carry_q <= sub ? 1'b1 : cin;
      idx_q   <= '0;
    end else if (state_q == RUN) begin
      for (int i = 0; i < NS; i++) begin
        if (idx_q == IW'(i)) begin
          sum_q[i*SLICE_W +: SLICE_W] <= s_sl;
        end
      end
      carry_q <= co;
      idx_q   <= is_last ? '0 : idx_q + 1'b1;
      if (is_last) begin
        cout_q <= co;
        ovf_q  <= (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                  (s_sl[SLICE_W-1] != a_q[WIDTH-1]);
      end
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule
